nv_blkbox_src_gen: RTL

- Parametrised, multi-channel successor to the fixed-constant tie-off source.
- Each channel is a programmable pattern source: constant, counter, walking-one or LFSR, with a valid/ready handshake.
- Drives unused or under-test datapath inputs in NVDLA sub-units and gives bring-up and verification a deterministic stimulus source.
- With the default configuration it behaves as a constant-0 source.

---
 rtl/nv_blkbox_src_gen_pkg.sv | 75 +++++++
 rtl/nv_blkbox_src_gen_chn.sv | 67 ++++++
 rtl/nv_blkbox_src_gen.sv | 51 +++++
 3 files changed

// File: rtl/nv_blkbox_src_gen_pkg.sv
// Shared definitions for the programmable black-box source generator:
// pattern mode encodings, default LFSR taps and the data update helpers.
package nv_blkbox_src_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_WALK1 = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    // Maximal-length Galois (right-shift) feedback masks per width.
    function automatic logic [31:0] lfsr_taps_for(input int w);
        logic [31:0] t;
        case (w)
            2:       t = 32'h0000_0003;
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0E08;
            13:      t = 32'h0000_1C80;
            14:      t = 32'h0000_3802;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_B400;
            24:      t = 32'h00E1_0000;
            32:      t = 32'h8020_0003;
            default: t = (32'd1 << (w - 1)) | 32'd1;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Value after one accepted beat; operands are zero-extended to 32 bits.
    function automatic logic [31:0] next_val(
        input mode_e       m,
        input logic [31:0] d,
        input logic [31:0] taps,
        input int          w
    );
        logic [31:0] r;
        case (m)
            MODE_COUNT: r = (d + 32'd1) & width_mask(w);
            MODE_WALK1: r = ((d << 1) | (d >> (w - 1))) & width_mask(w);
            MODE_LFSR:  r = (d >> 1) ^ (d[0] ? taps : 32'd0);
            default:    r = d;
        endcase
        return r;
    endfunction

    // Seed guard: WALK1/LFSR must never start from a stuck state.
    function automatic logic [31:0] guard_seed(
        input mode_e       m,
        input logic [31:0] s
    );
        logic [31:0] r;
        r = s;
        if (m == MODE_WALK1) begin
            // Two's-complement trick isolates the lowest set bit.
            r = (s == 32'd0) ? 32'd1 : (s & (~s + 32'd1));
        end else if (m == MODE_LFSR) begin
            r = (s == 32'd0) ? 32'd1 : s;
        end
        return r;
    endfunction

endpackage

// File: rtl/nv_blkbox_src_gen_chn.sv
// One pattern-source channel: data/mode registers, valid handshake, beat count.
// Ports: clk_i/rst_ni, en_i, cfg_wr_i/cfg_mode_i/cfg_seed_i, ready_i -> data_o, valid_o, cnt_o.
module nv_blkbox_src_chn
    import nv_blkbox_src_gen_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8),
    parameter int               CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             cfg_wr_i,
    input  mode_e            cfg_mode_i,
    input  logic [WIDTH-1:0] cfg_seed_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o
);

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign accept = valid_q & ready_i;

    always_comb begin
        mode_d  = mode_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // A pending beat keeps valid up regardless of the enable.
        valid_d = (valid_q & ~ready_i) | en_i;
        if (cfg_wr_i) begin
            // Config wins over a same-cycle accept.
            mode_d = cfg_mode_i;
            data_d = WIDTH'(guard_seed(cfg_mode_i, 32'(cfg_seed_i)));
            cnt_d  = '0;
        end else if (accept) begin
            data_d = WIDTH'(next_val(mode_q, 32'(data_q),
                                     32'(LFSR_TAPS), WIDTH));
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= MODE_CONST;
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/nv_blkbox_src_gen.sv
// Multi-channel programmable tie-off / stimulus source (CONST, COUNT, WALK1, LFSR).
// Ports: clock/reset, src_en, cfg_* write port, src_data/src_valid/src_ready, beat_cnt.
module nv_blkbox_src_gen
    import nv_blkbox_src_gen_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               NCH       = 2,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(lfsr_taps_for(WIDTH)),
    parameter int               CNT_W     = 16,
    localparam int              CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [NCH-1:0]         src_en,
    input  logic                   cfg_wr,
    input  logic [CHW-1:0]         cfg_ch,
    input  logic [1:0]             cfg_mode,
    input  logic [WIDTH-1:0]       cfg_seed,
    output logic [NCH*WIDTH-1:0]   src_data,
    output logic [NCH-1:0]         src_valid,
    input  logic [NCH-1:0]         src_ready,
    output logic [NCH*CNT_W-1:0]   beat_cnt
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic hit;

        // Out-of-range channel numbers match no instance.
        assign hit = cfg_wr && (32'(cfg_ch) == c);

        nv_blkbox_src_chn #(
            .WIDTH     (WIDTH),
            .RST_VAL   (RST_VAL),
            .LFSR_TAPS (LFSR_TAPS),
            .CNT_W     (CNT_W)
        ) u_chn (
            .clk_i      (nvdla_core_clk),
            .rst_ni     (nvdla_core_rstn),
            .en_i       (src_en[c]),
            .cfg_wr_i   (hit),
            .cfg_mode_i (mode_e'(cfg_mode)),
            .cfg_seed_i (cfg_seed),
            .ready_i    (src_ready[c]),
            .data_o     (src_data[c*WIDTH +: WIDTH]),
            .valid_o    (src_valid[c]),
            .cnt_o      (beat_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule
